// File: rtl/comparador_pkg.sv
// Shared types and the bit-cell update rule for the serial LSB-first magnitude comparator.
package comparador_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        RECIBE = 2'd1,
        FIN    = 2'd2
    } estado_t;

    localparam int N_DEF = 8;
    localparam int CNT_W = $clog2(N_DEF);

    // Returns {p, e}; a differing later bit overrides everything seen below it.
    function automatic logic [1:0] celda_update(
        input logic p,
        input logic e,
        input logic a,
        input logic b,
        input logic primero
    );
        logic [1:0] res;
        if (primero) begin
            res = {~a & b, ~(a ^ b)};
        end else if (a != b) begin
            res = {~a & b, 1'b0};
        end else begin
            res = {p, e};
        end
        return res;
    endfunction

endpackage

// File: rtl/celda_serial_d_i.sv
// Combinational comparator cell: initial rule on the first bit, general recurrence afterwards.
module celda_serial_d_i
    import comparador_pkg::*;
(
    input  logic a_p,
    input  logic b_p,
    input  logic p_in,
    input  logic e_in,
    input  logic primero,
    output logic p_out,
    output logic e_out
);

    // Next running state for the current bit pair.
    always_comb begin
        {p_out, e_out} = celda_update(p_in, e_in, a_p, b_p, primero);
    end

endmodule

// File: rtl/comparador_serial_d_i.sv
// Bit-serial LSB-first comparator of two N-bit words; one accepted bit pair per cycle.
module comparador_serial_d_i
    import comparador_pkg::*;
#(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inicio,
    input  logic bit_valido,
    input  logic a_p,
    input  logic b_p,
    output logic ocupado,
    output logic fin,
    output logic menor,
    output logic igual,
    output logic mayor
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    estado_t       estado;
    logic [CW-1:0] cuenta;
    logic          p;
    logic          e;
    logic          p_sig;
    logic          e_sig;
    logic          primero;

    assign primero = (cuenta == {CW{1'b0}});

    celda_serial_d_i u_celda (
        .a_p     (a_p),
        .b_p     (b_p),
        .p_in    (p),
        .e_in    (e),
        .primero (primero),
        .p_out   (p_sig),
        .e_out   (e_sig)
    );

    // Control FSM, running p/e state and registered outputs; result is latched on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= REPOSO;
            cuenta  <= {CW{1'b0}};
            p       <= 1'b0;
            e       <= 1'b1;
            ocupado <= 1'b0;
            fin     <= 1'b0;
            menor   <= 1'b0;
            igual   <= 1'b0;
            mayor   <= 1'b0;
        end else begin
            fin <= 1'b0;
            case (estado)
                REPOSO, FIN: begin
                    if (inicio) begin
                        estado  <= RECIBE;
                        cuenta  <= {CW{1'b0}};
                        ocupado <= 1'b1;
                    end else begin
                        estado  <= REPOSO;
                        ocupado <= 1'b0;
                    end
                end
                RECIBE: begin
                    if (inicio) begin
                        cuenta <= {CW{1'b0}};
                    end else if (bit_valido) begin
                        p <= p_sig;
                        e <= e_sig;
                        if (cuenta == ULTIMO) begin
                            // Latch the decision straight from the cell so it shows in the FIN cycle.
                            estado  <= FIN;
                            cuenta  <= {CW{1'b0}};
                            ocupado <= 1'b0;
                            fin     <= 1'b1;
                            menor   <= p_sig;
                            igual   <= e_sig;
                            mayor   <= ~p_sig & ~e_sig;
                        end else begin
                            cuenta <= cuenta + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        cuenta <= cuenta;
                    end
                end
                default: begin
                    estado  <= REPOSO;
                    cuenta  <= {CW{1'b0}};
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comparador_serial_d_i.sv
// Self-checking bench: directed table, hand-written abort/reset sequences, random words vs. integer compare.
module tb_comparador_serial_d_i;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst, inicio, bit_valido, a_p, b_p;
    logic ocupado, fin, menor, igual, mayor;

    int n_pass  = 0;
    int n_total = 0;

    comparador_serial_d_i #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .inicio     (inicio),
        .bit_valido (bit_valido),
        .a_p        (a_p),
        .b_p        (b_p),
        .ocupado    (ocupado),
        .fin        (fin),
        .menor      (menor),
        .igual      (igual),
        .mayor      (mayor)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           stall_at;
        int           stall_len;
        bit           junk;
        logic         menor;
        logic         igual;
        logic         mayor;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic ef, input logic em, input logic ei, input logic ema);
        chk({nm, " fin"}, fin, ef);
        chk({nm, " menor"}, menor, em);
        chk({nm, " igual"}, igual, ei);
        chk({nm, " mayor"}, mayor, ema);
    endtask

    // Start a word, feed its bits LSB first with an optional stall, then check fin timing and result.
    task automatic run_word(input logic [N-1:0] a, input logic [N-1:0] b, input int stall_at,
                            input int stall_len, input bit junk, input logic em, input logic ei,
                            input logic ema, input string nm);
        inicio     = 1'b1;
        bit_valido = junk;
        a_p        = 1'b0;
        b_p        = junk;
        tick;
        inicio     = 1'b0;
        bit_valido = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bit_valido = 1'b0;
                    a_p        = $urandom_range(0, 1);
                    b_p        = $urandom_range(0, 1);
                    tick;
                    chk({nm, " stall ocupado"}, ocupado, 1);
                end
            end
            chk({nm, " bit ocupado"}, ocupado, 1);
            chk({nm, " bit fin"}, fin, 0);
            bit_valido = 1'b1;
            a_p        = a[i];
            b_p        = b[i];
            tick;
        end
        bit_valido = 1'b0;
        chk_out(nm, 1'b1, em, ei, ema);
        chk({nm, " fin ocupado"}, ocupado, 0);
        tick;
        chk({nm, " fin pulse"}, fin, 0);
    endtask

    vec_t tabla[6];

    initial begin
        rst = 1'b1; inicio = 1'b0; bit_valido = 1'b0; a_p = 1'b0; b_p = 1'b0;

        tabla[0] = '{4'b0101, 4'b0110, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
        tabla[1] = '{4'b1010, 4'b1010, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tabla[2] = '{4'b1000, 4'b0111,  2, 3, 1'b0, 1'b0, 1'b0, 1'b1};
        tabla[3] = '{4'b1111, 4'b0000, -1, 0, 1'b1, 1'b0, 1'b0, 1'b1};
        tabla[4] = '{4'b0000, 4'b1000,  0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
        tabla[5] = '{4'b0001, 4'b0000, -1, 0, 1'b1, 1'b0, 1'b0, 1'b1};

        tick;
        tick;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset ocupado", ocupado, 0);
        rst = 1'b0;
        tick;
        chk("idle ocupado", ocupado, 0);

        for (int v = 0; v < 6; v++) begin
            run_word(tabla[v].a, tabla[v].b, tabla[v].stall_at, tabla[v].stall_len, tabla[v].junk,
                     tabla[v].menor, tabla[v].igual, tabla[v].mayor, $sformatf("vec%0d", v));
            if (v == 1) begin
                for (int h = 0; h < 10; h++) tick;
                chk_out("hold", 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end

        // Abort after two accepted bits; only the restarted word may produce fin.
        inicio = 1'b1; tick; inicio = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valido = 1'b1; a_p = 1'b1; b_p = 1'b0; tick;
            chk("abort fin", fin, 0);
        end
        run_word(4'b0011, 4'b0011, -1, 0, 1'b0, 1'b0, 1'b1, 1'b0, "restart");

        // Reset mid-word clears everything and leaves the block idle.
        inicio = 1'b1; tick; inicio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valido = 1'b1; a_p = 1'b0; b_p = 1'b1; tick;
        end
        bit_valido = 1'b1;
        rst = 1'b1; tick; rst = 1'b0;
        chk_out("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst ocupado", ocupado, 0);
        tick;
        chk("midrst idle fin", fin, 0);
        chk("midrst idle ocupado", ocupado, 0);
        bit_valido = 1'b0;
        run_word(4'b0001, 4'b0010, -1, 0, 1'b0, 1'b1, 1'b0, 1'b0, "postrst");

        // Random words against a plain integer comparison.
        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = (r % 5 == 0) ? ra : N'($urandom_range(0, (1 << N) - 1));
            bit_valido = 1'b1;
            a_p = $urandom_range(0, 1);
            b_p = $urandom_range(0, 1);
            tick;
            chk("rand idle fin", fin, 0);
            chk("rand idle ocupado", ocupado, 0);
            run_word(ra, rb, $urandom_range(0, N - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     ra < rb, ra == rb, ra > rb, $sformatf("rand%0d a=%0d b=%0d", r, ra, rb));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/comparador_serial_d_i.md
Name: comparador_serial_d_i

Overview:
- Bit-serial, LSB-first (right-to-left) magnitude comparator for two N-bit words A and B.
- Consumes one bit pair per accepted cycle and updates a running "A<B" / "A==B" state.
- Bit 0 uses the initial-cell rule `p = ~a & b`; every later bit uses the general-cell recurrence.
- Sits downstream of the combinational initial cell as the sequential replacement for the full iterative cell chain. It feeds the word-level decision logic.

Parameters:
- N, 8, word width in bits (number of bit pairs per comparison); legal range N ≥ 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- inicio  input  1  start pulse; begins a new comparison (aborts any comparison in progress).
- bit_valido  input  1  a_p/b_p carry a valid bit pair this cycle.
- a_p  input  1  current bit of A, LSB first.
- b_p  input  1  current bit of B, LSB first.
- ocupado  output  1  high while bits are being accepted (state RECIBE).
- fin  output  1  one-cycle pulse: result valid.
- menor  output  1  A<B.
- igual  output  1  A==B.
- mayor  output  1  A>B.

Behaviour:
- Reset (rst=1 at an edge): state REPOSO, counter=0, p=0, e=1.
  - Output values: ocupado=0, fin=0, menor=0, igual=0, mayor=0.
  - Reset mid-comparison discards all partial state; no fin is produced.
- States: REPOSO, RECIBE, FIN; state and all outputs are registered.
- REPOSO:
  - inicio=1 -> RECIBE, counter=0.
  - bit_valido is ignored in REPOSO, including in the inicio cycle.
  - Result outputs hold their last values.
- RECIBE:
  - bit_valido=0 -> stall; nothing changes.
  - bit_valido=1 at count 0 (initial cell): p <= ~a_p & b_p; e <= ~(a_p ^ b_p).
  - bit_valido=1 at count k>0 (general cell):
    - if a_p != b_p: p <= ~a_p & b_p, e <= 0;
    - else p and e hold.
  - Each accepted bit increments the counter.
  - When bit N-1 is accepted -> FIN.
- FIN (exactly one cycle):
  - fin=1, menor=p, igual=e, mayor=~p & ~e.
  - Next state REPOSO; result outputs hold until the next FIN or reset.
- Latency: inicio sampled at edge k; with no stalls, bits are sampled at edges k+1..k+N; fin is high in the cycle after edge k+N.
- Exactly one of menor/igual/mayor is 1 whenever fin=1.
- Simultaneous events:
  - inicio=1 in RECIBE or FIN -> restart: counter=0, RECIBE; that cycle's bit is not consumed; fin is not asserted for the aborted word.
  - rst has priority over inicio, which has priority over bit_valido.
- Counter width: $clog2(N); the counter never wraps, because the transition to FIN occurs at N-1.
- ocupado = (state == RECIBE).

Decomposition:
- Shared package comparador_pkg:
  - state enum {REPOSO, RECIBE, FIN};
  - localparam for counter width;
  - function for the cell update (p, e, a, b, first).
- Sub-module celda_serial_d_i: purely combinational; inputs a_p, b_p, p_in, e_in, primero; outputs p_out, e_out.
  - Instantiated once; its state registers live in the parent.

Test Plan:
- N=4, A=0101, B=0110 (LSB-first a=1,0,1,0; b=0,1,1,0), no stalls -> fin 5 cycles after inicio; menor=1, igual=0, mayor=0.
- N=4, A=B=1010 -> igual=1, menor=0, mayor=0; results still held 10 cycles after fin.
- N=4, A=1000, B=0111 (a=0,0,0,1; b=1,1,1,0), with bit_valido low for 3 cycles between bits 1 and 2 -> mayor=1; fin delayed by exactly 3 cycles; ocupado high throughout.
- N=4, inicio after 2 accepted bits, then full word A=0011, B=0011 -> single fin with igual=1; no fin for the aborted word.
- rst asserted after 3 accepted bits -> next cycle all outputs 0, state REPOSO; a subsequent inicio and word A=0001, B=0010 -> menor=1.
- N=4, A=1111, B=0000 -> mayor=1; inicio cycle with bit_valido=1 and a_p=0, b_p=1 is not counted.
